// File: rtl/i2c_master_byte.sv
// Byte-level I2C master engine: START+byte, byte and STOP commands, MSB-first shift, ACK sampling.
// Optional slave clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_master_byte #(
  parameter int QTR_CYCLES = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_en,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] tx_data,
  output logic       ready,
  output logic       tx_done,
  output logic       ack_err,
  output logic       bus_busy,
  output logic       scl,
  input  logic       scl_i,
  output logic       sda_oe,
  input  logic       sda_i
);

  typedef enum logic [2:0] {IDLE, RSTART, SHIFT, ACK, HOLD, STOPC} state_t;

  localparam int QW = (QTR_CYCLES > 2) ? $clog2(QTR_CYCLES) : 1;
  localparam logic [QW-1:0] QMAX = QW'(QTR_CYCLES - 1);

  state_t          state, state_nxt;
  logic [QW-1:0]   qcnt;
  logic [1:0]      phase;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [7:0]      cur_byte;
  logic            load_pend;
  logic            running;
  logic            stall;
  logic            phase_end;
  logic            accept;
  logic            bit_val;

  assign ready   = (state == IDLE) || (state == HOLD);
  // A byte or STOP command only makes sense while the bus is owned.
  assign accept  = ready && i2c_en && (start || (state == HOLD));
  assign running = (state == RSTART) || (state == SHIFT) || (state == ACK) || (state == STOPC);

`ifdef I2C_CLK_STRETCH_EN
  assign stall = !scl_i &&
                 ((((state == SHIFT) || (state == ACK)) && (phase == 2'd2)) ||
                  ((state == STOPC) && (phase == 2'd1)));
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign stall        = 1'b0;
`endif

  assign phase_end = running && !stall && (qcnt == QMAX);

  // The byte is latched one cycle after acceptance; until then drive straight from the input.
  assign cur_byte = load_pend ? tx_data : shreg;
  assign bit_val  = cur_byte[bit_idx];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RSTART;
      HOLD: begin
        if (accept) begin
          if (start)     state_nxt = RSTART;
          else if (stop) state_nxt = STOPC;
          else           state_nxt = SHIFT;
        end
      end
      RSTART:  if (phase_end && (phase == 2'd2)) state_nxt = SHIFT;
      SHIFT:   if (phase_end && (phase == 2'd3) && (bit_idx == 3'd0)) state_nxt = ACK;
      ACK:     if (phase_end && (phase == 2'd3)) state_nxt = HOLD;
      STOPC:   if (phase_end && (phase == 2'd3)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      qcnt      <= '0;
      phase     <= '0;
      bit_idx   <= '0;
      load_pend <= 1'b0;
      tx_done   <= 1'b0;
      ack_err   <= 1'b0;
      bus_busy  <= 1'b0;
    end else begin
      state     <= state_nxt;
      tx_done   <= 1'b0;
      load_pend <= accept;
      if (accept) begin
        qcnt    <= '0;
        phase   <= '0;
        bit_idx <= 3'd7;
        if (start) ack_err <= 1'b0;
      end else if (running && !stall) begin
        if (qcnt == QMAX) begin
          qcnt  <= '0;
          phase <= ((state == RSTART) && (phase == 2'd2)) ? 2'd0 : phase + 2'd1;
          if ((state == SHIFT) && (phase == 2'd3))          bit_idx  <= bit_idx - 3'd1;
          if ((state == ACK) && (phase == 2'd2) && sda_i)   ack_err  <= 1'b1;
          if ((state == ACK) && (phase == 2'd3))            tx_done  <= 1'b1;
          if ((state == RSTART) && (phase == 2'd1))         bus_busy <= 1'b1;
          if ((state == STOPC) && (phase == 2'd3))          bus_busy <= 1'b0;
        end else begin
          qcnt <= qcnt + QW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_pend) shreg <= tx_data;
  end

  // Open-drain line levels; bus_busy distinguishes a repeated START (SCL low in R0).
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state)
      RSTART: begin
        case (phase)
          2'd0:    scl = !bus_busy;
          2'd1:    scl = 1'b1;
          default: begin
            scl    = 1'b1;
            sda_oe = 1'b1;
          end
        endcase
      end
      SHIFT: begin
        scl    = phase[1];
        sda_oe = !bit_val;
      end
      ACK:     scl = phase[1];
      HOLD:    scl = 1'b0;
      STOPC: begin
        scl    = (phase != 2'd0);
        sda_oe = (phase < 2'd2);
      end
      default: begin
        scl    = 1'b1;
        sda_oe = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Self-checking bench for i2c_master_byte: directed vector table, hand sequences and
// randomized commands checked against a transaction-level model of the bus engine.
module tb_i2c_master_byte;
  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       reset, i2c_en, start, stop, sda_i, arm;
  logic [7:0] tx_data;
  logic       ready, tx_done, ack_err, bus_busy, scl, scl_i, sda_oe;

  always #5 clk = ~clk;
  assign scl_i = scl & ~arm;

  i2c_master_byte #(.QTR_CYCLES(Q)) dut (
    .clk(clk), .reset(reset), .i2c_en(i2c_en), .start(start), .stop(stop),
    .tx_data(tx_data), .ready(ready), .tx_done(tx_done), .ack_err(ack_err),
    .bus_busy(bus_busy), .scl(scl), .scl_i(scl_i), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Bus monitor: decodes START/STOP and bits sampled on SCL rise from the master's drive.
  bit prev_scl = 1'b1, prev_sda = 1'b1, mon_scl, mon_sda;
  int starts = 0, stops = 0;
  bit bits_q[$];
  always @(negedge clk) begin
    mon_scl = scl;
    mon_sda = !sda_oe;
    if (!reset) begin
      if (prev_scl && mon_scl && prev_sda && !mon_sda) begin
        starts++;
        bits_q.delete();
      end else if (prev_scl && mon_scl && !prev_sda && mon_sda) begin
        stops++;
      end else if (!prev_scl && mon_scl) begin
        bits_q.push_back(mon_sda);
      end
    end
    prev_scl = mon_scl;
    prev_sda = mon_sda;
  end

  int stretch_cnt = 0;
  always @(negedge clk) begin
    if (arm && scl) begin
      stretch_cnt++;
      if (stretch_cnt == 10) arm = 1'b0;
    end
  end

  typedef struct {
    bit         st;
    bit         sp;
    logic [7:0] d;
    bit         nk;
    int         exp_low;
    int         exp_done;
    int         exp_ack;
    int         exp_busy;
    int         exp_starts;
    int         exp_stops;
  } vec_t;

  vec_t vecs[10];

  task automatic run_cmd(input bit st, input bit sp, input logic [7:0] d, input bit nk,
                         output int low, output int dones);
    int guard;
    @(negedge clk);
    sda_i   = nk;
    start   = st;
    stop    = sp;
    tx_data = ~d;
    i2c_en  = 1'b1;
    bits_q.delete();
    @(posedge clk);
    #1;
    i2c_en  = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    tx_data = d;
    low   = 0;
    dones = 0;
    guard = 0;
    while (guard < 2000) begin
      @(negedge clk);
      if (tx_done) dones++;
      if (ready) break;
      low++;
      guard++;
      if (low == 2) tx_data = 8'($urandom);
    end
    if (guard >= 2000) check("cmd_timeout", 0, 1);
    @(negedge clk);
    if (tx_done) dones++;
  endtask

  task automatic check_bits(input string tag, input logic [7:0] d);
    int v;
    v = 0;
    check({tag, "_bitcount"}, bits_q.size(), 9);
    if (bits_q.size() == 9) begin
      foreach (bits_q[i]) v = (v << 1) | int'(bits_q[i]);
      check({tag, "_bits"}, v, int'({d, 1'b1}));
    end
  endtask

  // Transaction-level model state
  bit m_busy, m_ack;

  initial begin
    int low, dones, s0, p0, viol, exp_low, exp_done, exp_starts, exp_stops;
    bit st, sp, nk;
    logic [7:0] d;

    vecs[0] = '{1'b1, 1'b0, 8'hAA, 1'b0, 39*Q, 1, 0, 1, 1, 0};
    vecs[1] = '{1'b0, 1'b0, 8'h3C, 1'b1, 36*Q, 1, 1, 1, 0, 0};
    vecs[2] = '{1'b1, 1'b0, 8'h55, 1'b0, 39*Q, 1, 0, 1, 1, 0};
    vecs[3] = '{1'b0, 1'b0, 8'h0F, 1'b1, 36*Q, 1, 1, 1, 0, 0};
    vecs[4] = '{1'b1, 1'b1, 8'h81, 1'b0, 39*Q, 1, 0, 1, 1, 0};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b0, 4*Q,  0, 0, 0, 0, 1};
    vecs[6] = '{1'b0, 1'b0, 8'hC3, 1'b0, 0,    0, 0, 0, 0, 0};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 1'b0, 0,    0, 0, 0, 0, 0};
    vecs[8] = '{1'b1, 1'b0, 8'hE7, 1'b1, 39*Q, 1, 1, 1, 1, 0};
    vecs[9] = '{1'b0, 1'b1, 8'h00, 1'b0, 4*Q,  0, 1, 0, 0, 1};

    reset = 1'b0; i2c_en = 1'b0; start = 1'b0; stop = 1'b0;
    tx_data = 8'h00; sda_i = 1'b1; arm = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_scl", scl, 1);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_ready", ready, 1);
    check("rst_tx_done", tx_done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_bus_busy", bus_busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (scl !== 1'b1 || sda_oe !== 1'b0 || ready !== 1'b1 || bus_busy !== 1'b0) viol++;
    end
    check("idle_quiet", viol, 0);
    check("idle_no_start", starts, 0);

    foreach (vecs[i]) begin
      s0 = starts; p0 = stops;
      run_cmd(vecs[i].st, vecs[i].sp, vecs[i].d, vecs[i].nk, low, dones);
      check($sformatf("v%0d_ready_low", i), low, vecs[i].exp_low);
      check($sformatf("v%0d_tx_done", i), dones, vecs[i].exp_done);
      check($sformatf("v%0d_ack_err", i), ack_err, vecs[i].exp_ack);
      check($sformatf("v%0d_bus_busy", i), bus_busy, vecs[i].exp_busy);
      check($sformatf("v%0d_starts", i), starts - s0, vecs[i].exp_starts);
      check($sformatf("v%0d_stops", i), stops - p0, vecs[i].exp_stops);
      check($sformatf("v%0d_scl", i), scl, vecs[i].exp_busy ? 0 : 1);
      check($sformatf("v%0d_sda_oe", i), sda_oe, 0);
      if (vecs[i].exp_done == 1) check_bits($sformatf("v%0d", i), vecs[i].d);
    end

    m_busy = 1'b0;
    m_ack  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0:       begin st = 1'b1; sp = 1'b0; end
        1:       begin st = 1'b0; sp = 1'b1; end
        2:       begin st = 1'b0; sp = 1'b0; end
        default: begin st = 1'b1; sp = 1'b1; end
      endcase
      d  = 8'($urandom);
      nk = 1'($urandom);
      exp_starts = 0; exp_stops = 0; exp_low = 0; exp_done = 0;
      if (st) begin
        exp_low = 39*Q; exp_done = 1; exp_starts = 1; m_ack = nk; m_busy = 1'b1;
      end else if (m_busy && sp) begin
        exp_low = 4*Q; exp_stops = 1; m_busy = 1'b0;
      end else if (m_busy) begin
        exp_low = 36*Q; exp_done = 1; m_ack = m_ack | nk;
      end
      s0 = starts; p0 = stops;
      run_cmd(st, sp, d, nk, low, dones);
      check($sformatf("r%0d_ready_low", k), low, exp_low);
      check($sformatf("r%0d_tx_done", k), dones, exp_done);
      check($sformatf("r%0d_ack_err", k), ack_err, int'(m_ack));
      check($sformatf("r%0d_bus_busy", k), bus_busy, int'(m_busy));
      check($sformatf("r%0d_starts", k), starts - s0, exp_starts);
      check($sformatf("r%0d_stops", k), stops - p0, exp_stops);
      if (exp_done == 1) check_bits($sformatf("r%0d", k), d);
    end

    if (m_busy) begin
      run_cmd(1'b0, 1'b1, 8'h00, 1'b0, low, dones);
      check("pre_stop_low", low, 4*Q);
    end

    // START from IDLE with bus_busy timing, then asynchronous reset in the middle of bit 3.
    @(negedge clk);
    start = 1'b1; i2c_en = 1'b1; tx_data = 8'h00; sda_i = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0; i2c_en = 1'b0;
    for (int c = 0; c <= 78; c++) begin
      @(negedge clk);
      if (c == 7) check("busy_before_r2", bus_busy, 0);
      if (c == 8) begin
        check("busy_at_r2", bus_busy, 1);
        check("r2_sda_low", sda_oe, 1);
        check("r2_scl_high", scl, 1);
      end
    end
    check("mid_ready", ready, 0);
    check("mid_scl", scl, 0);
    check("mid_sda_oe", sda_oe, 1);
    #2 reset = 1'b1;
    #1;
    check("mrst_scl", scl, 1);
    check("mrst_sda_oe", sda_oe, 0);
    check("mrst_ready", ready, 1);
    check("mrst_bus_busy", bus_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    p0 = stops;
    repeat (20) @(negedge clk);
    check("mrst_no_stop", stops - p0, 0);
    check("mrst_idle_scl", scl, 1);

`ifdef I2C_CLK_STRETCH_EN
    run_cmd(1'b1, 1'b0, 8'h12, 1'b0, low, dones);
    check("str_start_low", low, 39*Q);
    stretch_cnt = 0;
    arm = 1'b1;
    run_cmd(1'b0, 1'b0, 8'hA5, 1'b0, low, dones);
    check("str_byte_low", low, 36*Q + 10);
    check("str_tx_done", dones, 1);
    check_bits("str", 8'hA5);
    arm = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
